mc_mem_responder: RTL
=====================

// Module: mc_mem_responder
// PURPOSE
//  Unified instruction/data memory that answers the multi-cycle MIPS core's fetch,
//  load and store requests through a req/ready handshake with programmable wait states.
//  Lets the control FSM stall in FETCH/MEMRD/MEMWR until memory responds, instead of
//  relying on a combinational single-cycle array.
//  Sits between the datapath address mux (iord) and the IR and data registers.
// PARAMETERS
//  DEPTH      256   number of 32-bit words; the address range is 0 .. 4*DEPTH-1 bytes
//  LATENCY    2     cycles from request acceptance to ready; legal values 1..15
//  INIT_FILE  ""    hex image loaded with $readmemh at time 0 when the string is non-empty
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-low reset
//  req     in   1   request strobe from the core
//  we      in   1   1 = store, 0 = load/fetch; sampled with req
//  addr    in   32  byte address; sampled with req
//  wdata   in   32  store data; sampled with req
//  busy    out  1   1 while a request is in flight (state WAIT)
//  ready   out  1   one-cycle pulse: response cycle; rdata/err valid while high
//  rdata   out  32  read data; holds its value until the next response
//  err     out  1   response flag: misaligned or out-of-range access; valid with ready
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, busy=0, ready=0, rdata=0, err=0, wait counter=0.
//   Reset does not clear or alter the memory array.
//  States:
//   IDLE -- no request in flight
//   WAIT -- counting down the wait states
//   RESP -- ready=1 for exactly one cycle
//  Accept: req=1 while state is IDLE or RESP. Requests in WAIT are ignored, with no queueing.
//  On accept: latch addr, we and wdata.
//   LATENCY=1: next state is RESP.
//   LATENCY>1: next state is WAIT with cnt=1.
//  WAIT: cnt increments each cycle; when cnt==LATENCY-1, next state is RESP.
//   Net timing: a request accepted in cycle T produces ready=1 in cycle T+LATENCY.
//  On entry to RESP (the edge that sets ready):
//   - error check: latched addr[1:0]!=0, or addr[31:2]>=DEPTH, gives err=1, rdata=0, no write
//   - otherwise err=0
//   - store with err=0: mem[addr[31:2]] <= wdata, and rdata <= wdata (write-through echo)
//   - load with err=0: rdata <= mem[addr[31:2]], giving the value before any write in the same edge
//  RESP next state:
//   - req=1: accept the new request (back-to-back, same rules as above)
//   - req=0: IDLE
//  busy = (state==WAIT). ready = (state==RESP). Both are registered outputs, not
//   combinational from the inputs.
//  Reset mid-operation: an in-flight request is dropped. No write occurs and no ready is
//   issued. After reset, the state is IDLE.
//  Inputs changing during WAIT have no effect, because only the latched copies are used.
//  Counter width is 4 bits. LATENCY outside 1..15 is illegal; the implementation flags it
//   with an elaboration-time $error.
// TESTING
//  1. Reset while LATENCY=2 and the core issues a store -> busy=0, ready=0, rdata=0, err=0;
//     after release the memory word is unchanged.
//  2. LATENCY=3: store req, addr=0x10, wdata=0xDEADBEEF in cycle T -> busy=1 in T+1..T+2,
//     ready=1 only in T+3, err=0; then load addr=0x10 -> rdata=0xDEADBEEF with ready.
//  3. Back-to-back: hold req=1 through RESP, load 0x10 then load 0x14 (preloaded 0x1234)
//     -> two ready pulses exactly LATENCY cycles apart; rdata 0xDEADBEEF, then 0x00001234.
//  4. Errors: load addr=0x13 -> ready with err=1, rdata=0.
//     Store addr=4*DEPTH -> err=1 and no array word changes (checked by readback sweep).
//  5. req pulsed during WAIT with a different addr -> ignored; the response matches the
//     first request and no extra ready follows.
//  6. Assert reset=0 one cycle before the expected ready of a store to 0x20
//     (old 0x0, wdata 0x55) -> no ready; a later load of 0x20 returns 0x0.

Source files
------------

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: unified instruction/data memory for the multi-cycle MIPS core.
// Requests use a req/ready handshake. A programmable number of wait states lets the
// control FSM stall in FETCH/MEMRD/MEMWR until the memory responds.
module mc_mem_responder #(
   parameter int    DEPTH     = 256,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 1);
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam bit          SINGLE   = (LATENCY == 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mc_mem_responder: LATENCY=%0d is outside 1..15", LATENCY);
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic [31:0] mem [DEPTH];

   logic             accept;
   logic             enter_resp;
   logic             tgt_we;
   logic [31:0]      tgt_addr;
   logic [31:0]      tgt_wdata;
   logic [IDX_W-1:0] tgt_idx;
   logic             tgt_err;
   logic             wr_en;

   // Decode which request is entering RESP on the coming edge and whether it is legal.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      accept     = 1'b0;
      enter_resp = 1'b0;
      tgt_we     = we;
      tgt_addr   = addr;
      tgt_wdata  = wdata;

      accept     = req && (state == IDLE || state == RESP);
      enter_resp = (SINGLE && accept) || (state == WAIT && cnt == CNT_LAST);

      // With LATENCY=1 the response edge is also the accept edge, so the live inputs
      // are the request; otherwise the copies latched at accept are used.
      if (state == WAIT) begin
         tgt_we    = lat_we;
         tgt_addr  = lat_addr;
         tgt_wdata = lat_wdata;
      end

      tgt_idx = tgt_addr[IDX_W+1:2];
      tgt_err = (tgt_addr[1:0] != 2'b00) || ({2'b00, tgt_addr[31:2]} >= DEPTH_W);
      // Reset is sampled here too so an edge seen while reset is held never writes.
      wr_en   = reset && enter_resp && tgt_we && !tgt_err;
   end

   // Handshake FSM with registered busy/ready/rdata/err and the latched request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         busy      <= 1'b0;
         ready     <= 1'b0;
         rdata     <= 32'd0;
         err       <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values, including the array read below.
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  lat_we    <= we;
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  if (SINGLE) begin
                     state <= RESP;
                     busy  <= 1'b0;
                     ready <= 1'b1;
                     cnt   <= 4'd0;
                  end else begin
                     state <= WAIT;
                     busy  <= 1'b1;
                     ready <= 1'b0;
                     cnt   <= 4'd1;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt == CNT_LAST) begin
                  state <= RESP;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               ready <= 1'b0;
            end
         endcase

         // Response payload is captured on the same edge that raises ready.
         if (enter_resp) begin
            err <= tgt_err;
            if (tgt_err)     rdata <= 32'd0;
            else if (tgt_we) rdata <= tgt_wdata;
            else             rdata <= mem[tgt_idx];
         end
      end
   end

   // Array write port; a load on the same edge still returns the old word.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset so it maps onto RAM and keeps its contents
      // across reset.
      if (wr_en) mem[tgt_idx] <= tgt_wdata;
   end

endmodule
